mem_arbiter: RTL and testbench

//  Two-master arbiter for the single-port instruction/data RAM of the RISC machine.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between two masters.
// Requests are serialised with round-robin fairness. The RAM read latency is
// absorbed in a counter-driven WAIT state. Each master sees a one-cycle ack,
// and read data is held in a per-master register.
module mem_arbiter #(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    grant
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          id_q;        // owner of the current transaction
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          last_q;      // master acked most recently (round-robin pointer)
    logic          excl_vld_q;  // previous cycle was DONE: that master sits out one arbitration
    logic          excl_id_q;
    logic [CW-1:0] cnt_q;       // remaining WAIT cycles minus one
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          elig0, elig1, win_vld, win_id;

    // Eligibility, winner selection and next-state decode
    always_comb begin
        state_d = state_q;
        win_vld = 1'b0;
        win_id  = 1'b0;
        elig0   = m0_req && !(excl_vld_q && !excl_id_q);
        elig1   = m1_req && !(excl_vld_q && excl_id_q);
        case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
                    win_vld = 1'b1;
                    win_id  = ~last_q;
                end else if (elig0) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (elig1) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
                if (win_vld) state_d = ACCESS;
            end
            ACCESS:  state_d = we_q ? DONE : WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, WAIT counter and round-robin / exclusion bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            excl_vld_q <= 1'b0;
            excl_id_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            excl_vld_q <= (state_q == DONE);
            excl_id_q  <= id_q;
            if (state_q == DONE) last_q <= id_q;
            if (state_q == ACCESS)
                cnt_q <= CW'(RD_LAT - 1);
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - CW'(1);
        end
    end

    // Latch the winning request; these registers drive the RAM port directly
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (win_vld) begin
            id_q    <= win_id;
            we_q    <= win_id ? m1_we    : m0_we;
            addr_q  <= win_id ? m1_addr  : m0_addr;
            wdata_q <= win_id ? m1_wdata : m0_wdata;
        end
    end

    // Capture RAM read data for the owner on the last WAIT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == WAIT && cnt_q == '0) begin
            if (id_q) rdata1_q <= ram_dout;
            else      rdata0_q <= ram_dout;
        end
    end

    assign ram_addr = addr_q;
    assign ram_din  = wdata_q;
    assign ram_we   = (state_q == ACCESS) && we_q;
    assign grant    = (state_q == IDLE) ? 2'b00 : {id_q, ~id_q};
    assign m0_ack   = (state_q == DONE) && !id_q;
    assign m1_ack   = (state_q == DONE) && id_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized two-master traffic on an
// RD_LAT=1 arbiter, checked every cycle against a transaction-level model.
// A second RD_LAT=3 instance covers the longer read latency.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // ---------------- instance A (RD_LAT = 1) ----------------
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack, a_ram_we;
    logic [DW-1:0] m0_rdata, m1_rdata, a_ram_din, a_ram_dout;
    logic [AW-1:0] a_ram_addr;
    logic [1:0]    a_grant;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_A)) u_dut_a (
        .clk(clk), .reset(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_din(a_ram_din),
        .ram_dout(a_ram_dout), .grant(a_grant)
    );

    // RAM A with a backdoor write port for preloading
    logic [DW-1:0] mem_a [0:511];
    logic          bd_we = 0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) mem_a[bd_addr] <= bd_data;
        else if (a_ram_we) mem_a[a_ram_addr] <= a_ram_din;
        a_ram_dout <= mem_a[a_ram_addr];
    end

    // ---------------- instance B (RD_LAT = 3) ----------------
    logic          b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
    logic [AW-1:0] b_m0_addr = '0, b_m1_addr = '0;
    logic [DW-1:0] b_m0_wdata = '0, b_m1_wdata = '0;
    logic          b_m0_ack, b_m1_ack, b_ram_we;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_ram_din, b_ram_dout;
    logic [AW-1:0] b_ram_addr;
    logic [1:0]    b_grant;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_B)) u_dut_b (
        .clk(clk), .reset(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_din(b_ram_din),
        .ram_dout(b_ram_dout), .grant(b_grant)
    );

    logic [DW-1:0] mem_b [0:511];
    logic [DW-1:0] b_p0, b_p1;
    always @(posedge clk) begin
        if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
        b_p0       <= mem_b[b_ram_addr];
        b_p1       <= b_p0;
        b_ram_dout <= b_p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ---------------- transaction-level model of instance A ----------------
    // One transaction at a time: granted in cycle start, RAM write in start+1,
    // ack in start+2 (write) or start+2+LAT_A (read), then the arbiter is free.
    logic [DW-1:0] model_mem [0:511];
    int            cyc = 0;
    bit            prev_rst = 0;
    bit            m_busy = 0;
    int            m_id, m_start, m_end;
    int            m_excl = -1;
    int            m_last = 1;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
    int            excl_cur, win;
    bit            e0, e1, exp_we, exp_a0, exp_a1;
    logic [1:0]    exp_g;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (prev_rst) begin
                chk("rst_grant", a_grant, 2'b00);
                chk("rst_we", a_ram_we, 1'b0);
                chk("rst_ack0", m0_ack, 1'b0);
                chk("rst_ack1", m1_ack, 1'b0);
                chk("rst_rdata0", m0_rdata, '0);
                chk("rst_rdata1", m1_rdata, '0);
                chk("rst_addr", a_ram_addr, '0);
                chk("rst_din", a_ram_din, '0);
            end
            // a write whose ACCESS cycle coincides with reset still lands
            if (m_busy && m_we && cyc == m_start + 1) model_mem[m_addr] = m_wd;
            m_busy = 0;
            m_excl = -1;
            m_last = 1;
            m_rd0 = '0;
            m_rd1 = '0;
            prev_rst = 1;
        end else begin
            prev_rst = 0;
            excl_cur = m_excl;
            m_excl = -1;
            exp_g = 2'b00;
            exp_we = 0;
            exp_a0 = 0;
            exp_a1 = 0;
            if (m_busy) begin
                exp_g = (m_id == 0) ? 2'b01 : 2'b10;
                exp_we = m_we && (cyc == m_start + 1);
                if (cyc < m_end) chk("m_addr", a_ram_addr, m_addr);
                if (exp_we) begin
                    chk("m_din", a_ram_din, m_wd);
                    model_mem[m_addr] = m_wd;
                end
                if (cyc == m_end) begin
                    if (m_id == 0) exp_a0 = 1; else exp_a1 = 1;
                    if (!m_we) begin
                        if (m_id == 0) m_rd0 = model_mem[m_addr];
                        else m_rd1 = model_mem[m_addr];
                    end
                    m_busy = 0;
                    m_excl = m_id;
                    m_last = m_id;
                end
            end else begin
                e0 = m0_req && (excl_cur != 0);
                e1 = m1_req && (excl_cur != 1);
                if (e0 || e1) begin
                    win = (e0 && e1) ? 1 - m_last : (e0 ? 0 : 1);
                    m_busy = 1;
                    m_id = win;
                    m_start = cyc;
                    m_we = (win == 0) ? m0_we : m1_we;
                    m_addr = (win == 0) ? m0_addr : m1_addr;
                    m_wd = (win == 0) ? m0_wdata : m1_wdata;
                    m_end = cyc + (m_we ? 2 : 2 + LAT_A);
                end
            end
            chk("m_grant", a_grant, exp_g);
            chk("m_we", a_ram_we, exp_we);
            chk("m_ack0", m0_ack, exp_a0);
            chk("m_ack1", m1_ack, exp_a1);
            chk("m_rdata0", m0_rdata, m_rd0);
            chk("m_rdata1", m1_rdata, m_rd1);
        end
        if (bd_we) model_mem[bd_addr] = bd_data;
    end

    // ---------------- random master driver ----------------
    bit rdone = 0;

    task automatic rand_master(input int id);
        logic a, req, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        bit nt;
        while (!rdone) begin
            mid();
            a = (id == 0) ? m0_ack : m1_ack;
            tick();
            req = (id == 0) ? m0_req : m1_req;
            nt = 0;
            if (req && a) begin
                if ($urandom_range(0, 1) == 1) nt = 1;
                else req = 0;
            end else if (!req && $urandom_range(0, 3) == 0) begin
                nt = 1;
            end
            we = $urandom_range(0, 1) == 1;
            addr = AW'($urandom_range(0, 31));
            wd = DW'($urandom);
            if (nt) req = 1;
            if (id == 0) begin
                m0_req = req;
                if (nt) begin m0_we = we; m0_addr = addr; m0_wdata = wd; end
            end else begin
                m1_req = req;
                if (nt) begin m1_we = we; m1_addr = addr; m1_wdata = wd; end
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [1:0] eg;
        int hold;

        // reset while preloading RAM A
        rst = 1;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            bd_we = 1;
            bd_addr = AW'(i);
            bd_data = DW'($urandom);
            tick();
        end
        bd_we = 0;
        mid();
        chk("t1_grant", a_grant, 2'b00);
        chk("t1_rdata0", m0_rdata, 16'h0000);
        rst = 0;
        tick();

        // m0 write addr 6 <- ABCD
        m0_req = 1; m0_we = 1; m0_addr = 9'd6; m0_wdata = 16'hABCD;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t2_we", a_ram_we, k == 1);
            chk("t2_ack", m0_ack, k == 2);
            if (k == 1) begin
                chk("t2_addr", a_ram_addr, 9'd6);
                chk("t2_din", a_ram_din, 16'hABCD);
            end
            tick();
        end
        m0_req = 0;
        chk("t2_ram6", mem_a[6], 16'hABCD);

        // preload addr 5 and 7, then m1 read addr 5
        bd_we = 1; bd_addr = 9'd5; bd_data = 16'hABCD;
        tick();
        bd_addr = 9'd7; bd_data = 16'h5A5A;
        tick();
        bd_we = 0;
        m1_req = 1; m1_we = 0; m1_addr = 9'd5;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("t3_we", a_ram_we, 1'b0);
            chk("t3_ack", m1_ack, k == 3);
            if (k == 3) chk("t3_rdata", m1_rdata, 16'hABCD);
            tick();
        end
        m1_req = 0;
        tick();
        mid();
        chk("t3_hold", m1_rdata, 16'hABCD);
        chk("t3_ack_off", m1_ack, 1'b0);
        tick();

        // reset during WAIT of an m0 read; held request served afterwards
        m0_req = 1; m0_we = 0; m0_addr = 9'd7;
        tick();
        tick();
        rst = 1;
        mid();
        chk("t5_ack_wait", m0_ack, 1'b0);
        tick();
        rst = 0;
        for (int k = 3; k < 7; k++) begin
            mid();
            chk("t5_ack", m0_ack, k == 6);
            chk("t5_grant", a_grant, (k == 3) ? 2'b00 : 2'b01);
            if (k == 3) chk("t5_rdata_rst", m0_rdata, 16'h0000);
            if (k == 6) chk("t5_rdata", m0_rdata, 16'h5A5A);
            tick();
        end
        m0_req = 0;
        tick();

        // both masters request continuously from reset: m0,m1,m0,m1
        rst = 1;
        m0_req = 1; m0_we = 1; m0_addr = 9'd20; m0_wdata = 16'h1111;
        m1_req = 1; m1_we = 1; m1_addr = 9'd21; m1_wdata = 16'h2222;
        tick();
        rst = 0;
        for (int k = 0; k < 12; k++) begin
            mid();
            eg = (k % 3 == 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
            chk("t4_grant", a_grant, eg);
            chk("t4_ack0", m0_ack, (k % 3 == 2) && ((k / 3) % 2 == 0));
            chk("t4_ack1", m1_ack, (k % 3 == 2) && ((k / 3) % 2 == 1));
            tick();
        end
        m0_req = 0;
        m1_req = 0;
        tick();
        tick();

        // m1 writes 1234 to addr 9, then m0 reads it, on both latencies
        m1_req = 1; m1_we = 1; m1_addr = 9'd9; m1_wdata = 16'h1234;
        b_m1_req = 1; b_m1_we = 1; b_m1_addr = 9'd9; b_m1_wdata = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t6_a_wack", m1_ack, k == 2);
            chk("t6_b_wack", b_m1_ack, k == 2);
            chk("t6_b_we", b_ram_we, k == 1);
            tick();
        end
        m1_req = 0;
        b_m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 9'd9;
        b_m0_req = 1; b_m0_we = 0; b_m0_addr = 9'd9;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("t6_a_ack", m0_ack, k == 3);
            chk("t6_b_ack", b_m0_ack, k == 5);
            chk("t6_b_rwe", b_ram_we, 1'b0);
            if (k == 3) chk("t6_a_rdata", m0_rdata, 16'h1234);
            if (k == 5) chk("t6_b_rdata", b_m0_rdata, 16'h1234);
            tick();
            if (k == 3) m0_req = 0;
            if (k == 5) b_m0_req = 0;
        end
        mid();
        chk("t6_b_hold", b_m0_rdata, 16'h1234);
        chk("t6_b_ack_off", b_m0_ack, 1'b0);
        tick();

        // randomized traffic with occasional two-cycle resets
        fork
            rand_master(0);
            rand_master(1);
            begin
                hold = 0;
                for (int c = 0; c < 6000; c++) begin
                    if (hold == 0 && $urandom_range(0, 199) == 0) hold = 2;
                    rst = (hold > 0);
                    if (hold > 0) hold--;
                    tick();
                end
                rst = 0;
                rdone = 1;
            end
        join
        m0_req = 0;
        m1_req = 0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
